// File: rtl/fetch_stage.sv
// fetch_stage: sequential instruction fetch with imem request/ready handshake, IF/ID register and skid buffer.
// Optional FETCH_ALIGN_CHECK_EN word-aligns branch targets and pulses misalign_fault.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc_out,
    output logic        valid,
    output logic        misalign_fault
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d, ir_q, ir_d, pc_q, pc_d;
    logic [31:0] buf_ir_q, buf_ir_d, buf_pc_q, buf_pc_d, target;
    logic        valid_q, valid_d, buf_valid_q, buf_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;
    assign target = {branch_target[31:2], 2'b00};
    always_ff @(posedge clk or posedge rst)
        if (rst) fault_q <= 1'b0;
        else     fault_q <= branch_taken & |branch_target[1:0];
    assign misalign_fault = fault_q;
`else
    assign target = branch_target;
    assign misalign_fault = 1'b0;
`endif
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        addr_d      = addr_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        buf_ir_d    = buf_ir_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;
        if (branch_taken) begin
            valid_d     = 1'b0;
            ir_d        = NOP_INSTR;
            buf_valid_d = 1'b0;
            fetch_pc_d  = target;
        end
        case (state_q)
            IDLE: begin
                if (branch_taken) begin
                    addr_d  = target;
                    state_d = REQ;
                end else if (!buf_valid_q || !stall) begin
                    if (buf_valid_q) begin
                        ir_d        = buf_ir_q;
                        pc_d        = buf_pc_q;
                        valid_d     = 1'b1;
                        buf_valid_d = 1'b0;
                    end
                    addr_d  = fetch_pc_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ready) begin
                    if (branch_taken) begin
                        addr_d = target;
                    end else if (!stall) begin
                        ir_d       = imem_rdata;
                        pc_d       = addr_q;
                        valid_d    = 1'b1;
                        fetch_pc_d = addr_q + 32'd4;
                        addr_d     = addr_q + 32'd4;
                    end else begin
                        buf_ir_d    = imem_rdata;
                        buf_pc_d    = addr_q;
                        buf_valid_d = 1'b1;
                        fetch_pc_d  = addr_q + 32'd4;
                        state_d     = IDLE;
                    end
                end else if (branch_taken) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // stale word is dropped; fetch_pc_d already reflects a same-cycle redirect
                if (imem_ready) begin
                    addr_d  = fetch_pc_d;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            addr_q      <= RESET_PC;
            ir_q        <= NOP_INSTR;
            pc_q        <= 32'd0;
            valid_q     <= 1'b0;
            buf_ir_q    <= 32'd0;
            buf_pc_q    <= 32'd0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            addr_q      <= addr_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            buf_ir_q    <= buf_ir_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
        end
    end
    assign imem_req  = (state_q != IDLE);
    assign imem_addr = addr_q;
    assign ir        = ir_q;
    assign pc_out    = pc_q;
    assign valid     = valid_q;
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage: the producer side of the IF/ID interface whose `ir` word the decode stage consumes. It generates sequential fetch addresses, runs a request/ready handshake to instruction memory, and holds IF/ID under decode stall through a one-entry skid buffer. It redirects on taken branches, discarding any in-flight fetch. It sits between the instruction MMU/cache port and the decoder.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_1000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: word driven on `ir` when IF/ID is empty (ADDI x0,x0,0).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: decode stall; IF/ID holds while 1.
- `branch_taken` in 1: redirect request, valid for one cycle.
- `branch_target` in 32: redirect address.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; stable while `imem_req`=1.
- `imem_ready` in 1: request completes in any cycle with `imem_req`&`imem_ready`.
- `imem_rdata` in 32: instruction word, valid in the completing cycle.
- `ir` out 32: IF/ID instruction register.
- `pc_out` out 32: address of `ir`.
- `valid` out 1: `ir` holds a real instruction.
- `misalign_fault` out 1: see Configuration.

## Operation
- Registers: `fetch_pc` (next address to fetch), `imem_addr`, IF/ID (`ir`, `pc_out`, `valid`), skid buffer (`buf_ir`, `buf_pc`, `buf_valid`).
- `imem_req` = (state != IDLE). It is registered.
- Once asserted, a request is never withdrawn or re-addressed before completion.
- Flush: `valid`←0, `ir`←NOP_INSTR, `buf_valid`←0, `fetch_pc`←`branch_target`.
- Branch has priority over stall and over completion data.

FSM, states IDLE, REQ, DRAIN:
- **IDLE** (no request outstanding):
  - If `branch_taken`: flush; `imem_addr`←target; go to REQ.
  - Else if `buf_valid` & !`stall`: IF/ID←buffer; `buf_valid`←0; `imem_addr`←`fetch_pc`; go to REQ.
  - Else if !`buf_valid`: `imem_addr`←`fetch_pc`; go to REQ.
  - Else stay in IDLE.
- **REQ**, cycle with `imem_ready`=1:
  - If `branch_taken`: discard data; flush; `imem_addr`←target; stay in REQ.
  - Else if !`stall`: IF/ID←{`imem_rdata`, `imem_addr`, 1}; `fetch_pc`,`imem_addr`←`imem_addr`+4; stay in REQ.
  - Else (`stall`=1): buffer←{`imem_rdata`, `imem_addr`}; `buf_valid`←1; `fetch_pc`←`imem_addr`+4; go to IDLE.
- **REQ**, cycle with `imem_ready`=0:
  - If `branch_taken`: flush; go to DRAIN. `imem_addr` is unchanged.
  - Else stay in REQ.
- **DRAIN** (in-flight request whose data will be discarded):
  - `branch_taken` updates `fetch_pc` (flush) in every cycle.
  - On `imem_ready`: discard data; `imem_addr`←`fetch_pc`, using the new target if a branch arrives in the same cycle; go to REQ.
- Address arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: state=IDLE; `fetch_pc`=`imem_addr`=RESET_PC; `imem_req`=0; `ir`=NOP_INSTR; `pc_out`=0; `valid`=0; `buf_valid`=0; `misalign_fault`=0.
- Reset mid-request drops `imem_req` immediately and abandons the request.
- First `imem_req`=1 appears after the first rising edge with `rst` low.
- Zero-wait memory (`imem_ready` tied 1): one instruction per cycle. `ir` updates on the edge that completes the request; fetch-to-IF/ID latency is 1 cycle after completion.
- Taken branch: `valid`=0 the following cycle.
  - Issued from REQ with `imem_ready`=1: the target request is on the bus the next cycle, so the first target instruction reaches IF/ID at the earliest 2 cycles after the branch.
  - Issued from REQ with `imem_ready`=0: the target request waits for DRAIN to complete.
- Stall: IF/ID unchanged in every stalled cycle. At most one extra word is captured in the buffer, and no new request issues while `buf_valid`=1. Buffer-to-IF/ID transfer happens on the first edge with `stall`=0.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A taken branch with `branch_target[1:0]`≠0 loads the target with bits[1:0] forced to 0.
  - `misalign_fault` pulses 1 for exactly the cycle after the branch.
- Undefined: the target is used unmodified and `misalign_fault` is tied 0.

## Test plan
- Reset release, `imem_ready`=1, `imem_rdata`=addr: `imem_addr` sequence 0x1000, 0x1004, 0x1008; `ir`/`pc_out` follow 1 cycle later; `valid`=1 from the first completion.
- `stall`=1 for 3 cycles while the request for 0x1008 completes: IF/ID holds 0x1004; the buffer captures 0x1008; `imem_req`=0. After `stall` drops, `pc_out`=0x1008 then 0x100C with no lost or duplicated word.
- `imem_ready`=0 for 4 cycles at 0x2000, `branch_taken` with target 0x3000 in cycle 1: `imem_addr` stays 0x2000 until ready; the 0x2000 data never reaches `ir`; the next request is 0x3000.
- `branch_taken` (target 0x4000) and `stall`=1 in the same completing cycle: flush wins; `valid`=0, `buf_valid`=0, next `imem_addr`=0x4000.
- `fetch_pc`=0xFFFF_FFFC with ready: next `imem_addr`=0x0000_0000.
- With `FETCH_ALIGN_CHECK_EN`, target 0x5002: next `imem_addr`=0x5000 and a one-cycle `misalign_fault`. Without the macro: `imem_addr`=0x5002 and `misalign_fault`=0.
